// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, stall/redirect handling.
// Optional halt detection on 32'hFFFFFFFF is compiled in with `define HALT_DETECT_EN.
module instruction_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic [4:0]  pointer,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [4:0]  branch_target,
    output logic [31:0] if_id_instr,
    output logic [4:0]  if_id_pc,
    output logic        if_id_valid,
    output logic        halted
);

`ifdef HALT_DETECT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t     state, state_next;
    logic [4:0] pc;
    logic       capture;
    logic       redirect;
    logic       halt_hit;
    logic       in_halt;

    assign pointer = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = RUN;
`ifdef HALT_DETECT_EN
            RUN:  if (capture && halt_hit) state_next = HALT;
`endif
            default: ;
        endcase
    end

    // Branch wins over stall; a capture only happens on a clean RUN cycle.
    always_comb begin
        redirect = (state == RUN) && branch_taken;
        capture  = (state == RUN) && !branch_taken && !stall;
`ifdef HALT_DETECT_EN
        halt_hit = (instruction == 32'hFFFF_FFFF);
        in_halt  = (state == HALT);
`else
        halt_hit = 1'b0;
        in_halt  = 1'b0;
`endif
        halted   = in_halt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= 5'd0;
            if_id_instr <= 32'h0;
            if_id_pc    <= 5'd0;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= branch_target;
            if_id_instr <= 32'h0;
            if_id_pc    <= 5'd0;
            if_id_valid <= 1'b0;
        end else if (capture) begin
            if_id_instr <= instruction;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            // The halt word freezes PC on its own address.
            if (!halt_hit) pc <= pc + 5'd1;
        end else if (in_halt) begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// stall/branch traffic compared against a transaction-level fetch model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [4:0]  pointer;
    logic [31:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [4:0]  branch_target;
    logic [31:0] if_id_instr;
    logic [4:0]  if_id_pc;
    logic        if_id_valid;
    logic        halted;

    logic [31:0] mem [32];

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          m_started;
    bit          m_halt;
    int          m_pc;
    logic [31:0] m_instr;
    int          m_ipc;
    bit          m_valid;

`ifdef HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    instruction_fetch dut (
        .clk(clk), .rst(rst), .pointer(pointer), .instruction(instruction),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .halted(halted)
    );

    assign instruction = mem[pointer];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            if (mem[i] == 32'hFFFF_FFFF) mem[i] = 32'h0;
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_halt = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0;
    endtask

    // One clock edge of the fetch stage, stated in terms of what the stage promises.
    task automatic model_step();
        if (!m_started) begin
            m_started = 1;
        end else if (m_halt) begin
            m_valid = 0;
        end else if (branch_taken) begin
            m_pc = branch_target; m_instr = 0; m_ipc = 0; m_valid = 0;
        end else if (!stall) begin
            m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1;
            if (HALT_EN && mem[m_pc] == 32'hFFFF_FFFF) m_halt = 1;
            else m_pc = (m_pc + 1) % 32;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, release it a little later, still before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        stall = 0; branch_taken = 0; branch_target = 0;
        rst = 1'b1;
        model_reset();
        #3;
        checks++;
        if ({pointer, if_id_instr, if_id_pc, if_id_valid, halted} !== 44'h0) begin
            errors++;
            $display("FAIL reset_state: got ptr=%0d instr=%h pc=%0d v=%b h=%b, need all zero",
                     pointer, if_id_instr, if_id_pc, if_id_valid, halted);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        fill_mem();
        mem[3] = 32'h8C11_0008;
        do_reset();
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || pointer !== 5'd0) begin
            errors++;
            $display("FAIL idle_edge: got v=%b ptr=%0d, need v=0 ptr=0", if_id_valid, pointer);
        end
        repeat (4) tick();
        checks++;
        if (if_id_pc !== 5'd3 || if_id_instr !== 32'h8C11_0008 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_fetch_5th_edge: got pc=%0d instr=%h v=%b, need pc=3 instr=8c110008 v=1",
                     if_id_pc, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_wrap();
        fill_mem();
        do_reset();
        tick();
        for (int k = 0; k < 33; k++) begin
            tick();
            checks++;
            if (if_id_pc !== 5'(k % 32) || if_id_instr !== mem[k % 32] || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_capture[%0d]: got pc=%0d instr=%h v=%b, need pc=%0d instr=%h v=1",
                         k, if_id_pc, if_id_instr, if_id_valid, k % 32, mem[k % 32]);
            end
        end
        checks++;
        if (pointer !== 5'd1) begin
            errors++;
            $display("FAIL wrap_pointer: got %0d, need 1", pointer);
        end
    endtask

    task automatic test_stall();
        fill_mem();
        do_reset();
        repeat (6) tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pointer !== 5'd5 || if_id_pc !== 5'd4 || if_id_instr !== mem[4] || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got ptr=%0d pc=%0d instr=%h v=%b, need ptr=5 pc=4 instr=%h v=1",
                         k, pointer, if_id_pc, if_id_instr, if_id_valid, mem[4]);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (if_id_pc !== 5'd5 || if_id_instr !== mem[5] || pointer !== 5'd6) begin
            errors++;
            $display("FAIL stall_release: got pc=%0d instr=%h ptr=%0d, need pc=5 instr=%h ptr=6",
                     if_id_pc, if_id_instr, pointer, mem[5]);
        end
    endtask

    task automatic test_branch_stall();
        fill_mem();
        do_reset();
        repeat (8) tick();
        branch_taken = 1'b1; stall = 1'b1; branch_target = 5'd20;
        tick();
        checks++;
        if (pointer !== 5'd20 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 5'd0) begin
            errors++;
            $display("FAIL branch_redirect: got ptr=%0d v=%b instr=%h pc=%0d, need ptr=20 v=0 instr=0 pc=0",
                     pointer, if_id_valid, if_id_instr, if_id_pc);
        end
        branch_taken = 1'b0; stall = 1'b0;
        tick();
        checks++;
        if (if_id_pc !== 5'd20 || if_id_instr !== mem[20] || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_target_fetch: got pc=%0d instr=%h v=%b, need pc=20 instr=%h v=1",
                     if_id_pc, if_id_instr, if_id_valid, mem[20]);
        end
    endtask

    task automatic test_async_reset();
        fill_mem();
        do_reset();
        repeat (13) tick();
        checks++;
        if (pointer !== 5'd12) begin
            errors++;
            $display("FAIL async_setup: got ptr=%0d, need 12", pointer);
        end
        #3;
        branch_taken = 1'b1; branch_target = 5'd17;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (pointer !== 5'd0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_immediate: got ptr=%0d v=%b instr=%h, need ptr=0 v=0 instr=0",
                     pointer, if_id_valid, if_id_instr);
        end
        #1;
        rst = 1'b0;
        tick();  // IDLE edge: branch must be ignored
        branch_taken = 1'b0;
        tick();
        checks++;
        if (if_id_pc !== 5'd0 || if_id_valid !== 1'b1 || pointer !== 5'd1) begin
            errors++;
            $display("FAIL reset_discards_redirect: got pc=%0d v=%b ptr=%0d, need pc=0 v=1 ptr=1",
                     if_id_pc, if_id_valid, pointer);
        end
    endtask

    task automatic test_halt();
        fill_mem();
        mem[4] = 32'hFFFF_FFFF;
        do_reset();
        repeat (6) tick();
        if (HALT_EN) begin
            checks++;
            if (halted !== 1'b1 || pointer !== 5'd4 || if_id_pc !== 5'd4 ||
                if_id_instr !== 32'hFFFF_FFFF || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL halt_capture: got h=%b ptr=%0d pc=%0d instr=%h v=%b, need h=1 ptr=4 pc=4 instr=ffffffff v=1",
                         halted, pointer, if_id_pc, if_id_instr, if_id_valid);
            end
            branch_taken = 1'b1; branch_target = 5'd9;
            for (int k = 0; k < 3; k++) begin
                stall = 1'($urandom_range(0, 1));
                tick();
                checks++;
                if (halted !== 1'b1 || pointer !== 5'd4 || if_id_pc !== 5'd4 || if_id_valid !== 1'b0 ||
                    if_id_instr !== 32'hFFFF_FFFF) begin
                    errors++;
                    $display("FAIL halt_hold[%0d]: got h=%b ptr=%0d pc=%0d v=%b instr=%h, need h=1 ptr=4 pc=4 v=0 instr=ffffffff",
                             k, halted, pointer, if_id_pc, if_id_valid, if_id_instr);
                end
            end
        end else begin
            checks++;
            if (halted !== 1'b0 || pointer !== 5'd5 || if_id_instr !== 32'hFFFF_FFFF || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL no_halt_capture: got h=%b ptr=%0d instr=%h v=%b, need h=0 ptr=5 instr=ffffffff v=1",
                         halted, pointer, if_id_instr, if_id_valid);
            end
            tick();
            checks++;
            if (if_id_pc !== 5'd5 || halted !== 1'b0 || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL no_halt_continue: got pc=%0d h=%b v=%b, need pc=5 h=0 v=1",
                         if_id_pc, halted, if_id_valid);
            end
        end
        branch_taken = 1'b0; stall = 1'b0;
        do_reset();
    endtask

    task automatic test_random();
        fill_mem();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = 5'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #3;
                do_reset();
            end
            tick();
            checks++;
            if ({pointer, if_id_instr, if_id_pc, if_id_valid, halted} !==
                {5'(m_pc), m_instr, 5'(m_ipc), m_valid, m_halt}) begin
                errors++;
                $display("FAIL random[%0d]: got ptr=%0d instr=%h pc=%0d v=%b h=%b, need ptr=%0d instr=%h pc=%0d v=%b h=%b",
                         n, pointer, if_id_instr, if_id_pc, if_id_valid, halted,
                         m_pc, m_instr, m_ipc, m_valid, m_halt);
            end
        end
        stall = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 5'd0;
        fill_mem();
        #1;
        test_reset();
        test_sequential();
        test_wrap();
        test_stall();
        test_branch_stall();
        test_async_reset();
        test_halt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port pointer, output, 5 bits: word address driven to the instruction memory, equal to the current PC register.
REQ-004 SHALL have port instruction, input, 32 bits: combinational read data from the instruction memory for the current pointer.
REQ-005 SHALL have port stall, input, 1 bit: holds PC and IF/ID outputs.
REQ-006 SHALL have port branch_taken, input, 1 bit: redirects PC and flushes IF/ID.
REQ-007 SHALL have port branch_target, input, 5 bits: redirect address.
REQ-008 SHALL have port if_id_instr, output, 32 bits: registered fetched instruction.
REQ-009 SHALL have port if_id_pc, output, 5 bits: registered address of if_id_instr.
REQ-010 SHALL have port if_id_valid, output, 1 bit: if_id_instr holds a real fetch, not a bubble.
REQ-011 SHALL have port halted, output, 1 bit: high while in HALT; tied 0 when HALT_DETECT_EN is undefined.

Function
REQ-012 SHALL implement states IDLE, RUN and HALT; HALT exists only with HALT_DETECT_EN.
REQ-013 SHALL drive pointer combinationally from the PC register, with zero added latency.
REQ-014 SHALL transition IDLE -> RUN unconditionally on the first rising edge after rst deasserts; no capture occurs in IDLE, so if_id_valid stays 0.
REQ-015 In RUN with stall=0 and branch_taken=0, each edge SHALL load if_id_instr<=instruction, if_id_pc<=PC, if_id_valid<=1 and PC<=PC+1.
REQ-016 PC arithmetic SHALL be 5-bit modulo 32: PC=31 increments to 0, with no flag and no stop.
REQ-017 In RUN with stall=1 and branch_taken=0, PC, if_id_instr, if_id_pc and if_id_valid SHALL hold their values.
REQ-018 In RUN with branch_taken=1, the edge SHALL load PC<=branch_target, if_id_instr<=32'h0 (nop), if_id_pc<=0 and if_id_valid<=0, regardless of stall; branch has priority over stall.
REQ-019 After a redirect, the next unstalled edge SHALL capture the instruction at branch_target; the redirect penalty is exactly one bubble.
REQ-020 branch_taken and stall SHALL be ignored in IDLE and HALT.
REQ-021 Every output SHALL change only at clk edges or on rst, except pointer, which tracks the PC register.

Reset
REQ-022 rst=1 SHALL asynchronously force PC=0, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0 and state=IDLE.
REQ-023 rst asserted mid-stall, mid-redirect or in HALT SHALL take effect immediately, and the pending redirect SHALL be discarded.
REQ-024 After rst release, fetch SHALL resume from address 0 per REQ-014.

Configuration
REQ-025 Macro HALT_DETECT_EN SHALL gate halt detection.
REQ-026 With HALT_DETECT_EN defined, a RUN-state capture of instruction==32'hFFFFFFFF SHALL latch it into IF/ID with if_id_valid=1, then on that edge set state=HALT and halted=1, and freeze PC at the halt address.
REQ-027 With HALT_DETECT_EN defined, each edge in HALT SHALL hold PC, if_id_instr and if_id_pc, and force if_id_valid<=0; exit from HALT SHALL be by rst only.
REQ-028 Without HALT_DETECT_EN, 32'hFFFFFFFF SHALL be fetched as an ordinary instruction, HALT SHALL be unreachable, and halted SHALL be constant 0.

Verification
REQ-029 The bench SHALL cover sequential fetch: memory[3]=32'h8C110008 with no stall -> on the 5th edge after rst release, if_id_pc=3, if_id_instr=32'h8C110008, if_id_valid=1.
REQ-030 The bench SHALL cover wrap-around: run free for 33 capture edges -> the captured if_id_pc sequence is 0..31, 0, and pointer returns to 1.
REQ-031 The bench SHALL cover stall: stall=1 for 3 edges while PC=5 -> pointer=5 and IF/ID unchanged for 3 edges; the next edge captures address 5.
REQ-032 The bench SHALL cover branch with stall: branch_taken=1, stall=1, branch_target=20 at PC=7 -> next edge gives pointer=20, if_id_valid=0, if_id_instr=0; the following edge gives if_id_pc=20.
REQ-033 The bench SHALL cover async reset: rst pulsed between edges while PC=12 -> pointer=0 and if_id_valid=0 immediately, before the next clk edge.
REQ-034 The bench SHALL cover halt: with HALT_DETECT_EN defined and memory[4]=32'hFFFFFFFF -> halted=1 after the capture of address 4, pointer stays 4, if_id_valid=0 on later edges; without the macro, fetch continues to address 5.
